dma_hold_arbiter: RTL



---
 rtl/dma_hold_arbiter_pkg.sv | 19 +
 rtl/dma_hold_arbiter_priority_encoder.sv | 20 ++
 rtl/dma_hold_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dma_hold_arbiter_pkg.sv
// Shared FSM state type, CPU status constant and DACK helper for the DMA hold arbiter.
package dma_hold_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PASSIVE,
    AEN,
    ACK,
    RELEASE
  } arb_state_t;

  localparam logic [2:0] STATUS_PASSIVE = 3'b111;
  localparam int         NUM_CHANNELS   = 4;

  function automatic logic [NUM_CHANNELS-1:0] dack_vector(input logic [1:0] channel);
    dack_vector = ~(4'b0001 << channel);
  endfunction

endpackage

// File: rtl/dma_hold_arbiter_priority_encoder.sv
// Combinational 4-way priority select; 'rotate' names the channel that currently has top priority.
module dma_priority_encoder
  import dma_hold_arbiter_pkg::*;
(
  input  logic [NUM_CHANNELS-1:0] request,
  input  logic [1:0]              rotate,
  output logic                    valid,
  output logic [1:0]              channel
);

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    valid   = |request;
    channel = rotate;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (request[rotate + 2'(i)]) channel = rotate + 2'(i);
    end
  end

endmodule

// File: rtl/dma_hold_arbiter.sv
// Bus hold arbiter: takes the bus from the CPU on a passive, unlocked cycle and grants one DMA channel.
// Define ROTATE_PRIORITY_EN for rotating priority; fixed priority 0 > 1 > 2 > 3 otherwise.
module dma_hold_arbiter
  import dma_hold_arbiter_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 2,
  parameter int RELEASE_CYCLES  = 1,
  parameter int WATCHDOG_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       timer_counter_1,
  input  logic [3:0] dma_request,
  input  logic [3:0] channel_mask,
  input  logic [2:0] processor_status,
  input  logic       processor_lock_n,
  input  logic       transfer_done,
  output logic       address_enable_n,
  output logic [3:0] dma_acknowledge_n,
  output logic       dma_wait_n,
  output logic [1:0] grant_channel,
  output logic       watchdog_timeout
);

  localparam logic [4:0] SETTLE_LIMIT   = 5'(SETTLE_CYCLES);
  localparam logic [4:0] RELEASE_LIMIT  = 5'(RELEASE_CYCLES);
  localparam logic [8:0] WATCHDOG_LIMIT = 9'(WATCHDOG_CYCLES);

  arb_state_t state;
  logic       timer_prev;
  logic       refresh;
  logic [3:0] eff_request;
  logic       any_request;
  logic [1:0] pick;
  logic [1:0] rotate_ptr;
  logic       passive_cycle;
  logic [3:0] settle_cnt;
  logic [3:0] release_cnt;
  logic [7:0] watchdog_cnt;

  assign eff_request = {dma_request[3:1] & ~channel_mask[3:1],
                        (dma_request[0] | refresh) & ~channel_mask[0]};
  assign passive_cycle = (processor_status == STATUS_PASSIVE) && processor_lock_n;

  dma_priority_encoder u_priority_encoder (
    .request (eff_request),
    .rotate  (rotate_ptr),
    .valid   (any_request),
    .channel (pick)
  );

`ifdef ROTATE_PRIORITY_EN
  // The channel just granted drops to lowest priority; the next one up becomes highest.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rotate_ptr <= 2'd0;
    else if (state == AEN) rotate_ptr <= grant_channel + 2'd1;
  end
`else
  assign rotate_ptr = 2'd0;
`endif

  // Refresh request: a new timer edge beats the clear issued on channel-0 ACK entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_prev <= 1'b1;
      refresh    <= 1'b0;
    end else begin
      timer_prev <= timer_counter_1;
      if (timer_counter_1 && !timer_prev) refresh <= 1'b1;
      else if (state == AEN && grant_channel == 2'd0) refresh <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      grant_channel     <= 2'd0;
      settle_cnt        <= 4'd0;
      release_cnt       <= 4'd0;
      watchdog_cnt      <= 8'd0;
      address_enable_n  <= 1'b1;
      dma_acknowledge_n <= 4'hF;
      dma_wait_n        <= 1'b1;
      watchdog_timeout  <= 1'b0;
    end else begin
      watchdog_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_request) begin
            grant_channel <= pick;
            settle_cnt    <= 4'd0;
            state         <= WAIT_PASSIVE;
          end
        end
        WAIT_PASSIVE: begin
          if (!eff_request[grant_channel]) begin
            state <= IDLE;
          end else if (passive_cycle) begin
            if ({1'b0, settle_cnt} + 5'd1 >= SETTLE_LIMIT) begin
              state            <= AEN;
              address_enable_n <= 1'b0;
              dma_wait_n       <= 1'b0;
            end else if (settle_cnt != 4'hF) begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end else begin
            settle_cnt <= 4'd0;
          end
        end
        AEN: begin
          state             <= ACK;
          dma_acknowledge_n <= dack_vector(grant_channel);
          watchdog_cnt      <= 8'd0;
        end
        // The watchdog counter holds the number of completed ACK cycles.
        ACK: begin
          if (transfer_done) begin
            state             <= RELEASE;
            dma_acknowledge_n <= 4'hF;
            release_cnt       <= 4'd0;
          end else if ({1'b0, watchdog_cnt} + 9'd1 == WATCHDOG_LIMIT) begin
            state             <= RELEASE;
            dma_acknowledge_n <= 4'hF;
            release_cnt       <= 4'd0;
            watchdog_timeout  <= 1'b1;
          end else if (watchdog_cnt != 8'hFF) begin
            watchdog_cnt <= watchdog_cnt + 8'd1;
          end
        end
        RELEASE: begin
          if ({1'b0, release_cnt} + 5'd1 >= RELEASE_LIMIT) begin
            state            <= IDLE;
            address_enable_n <= 1'b1;
            dma_wait_n       <= 1'b1;
          end else if (release_cnt != 4'hF) begin
            release_cnt <= release_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
